// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the iterative multiply/divide write-back unit.
package muldiv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 6;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULHU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_REM   = 3'd4,
    OP_REMU  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Quotient returned for any divide by zero; sliced to XLEN by the user.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 shift-add multiply / restoring divide datapath, one iteration per step_i.
// acc holds {hi, lo}: {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_mode_i,
  input  logic [XLEN-1:0]   lo_init_i,
  input  logic [XLEN-1:0]   opnd_init_i,
  output logic [2*XLEN-1:0] acc_nxt_o
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     diff;

  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_ext   = acc_q[2*XLEN-1:XLEN-1];
    diff      = rem_ext - {1'b0, opnd_q};
    acc_nxt_o = {add_sum, acc_q[XLEN-1:1]};
    // diff[XLEN] is the borrow: set means the trial subtract is undone.
    if (div_mode_i) begin
      acc_nxt_o = {(diff[XLEN] ? rem_ext[XLEN-1:0] : diff[XLEN-1:0]),
                   acc_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      acc_q  <= {{XLEN{1'b0}}, lo_init_i};
      opnd_q <= opnd_init_i;
    end else if (step_i) begin
      acc_q  <= acc_nxt_o;
    end
  end

endmodule

// File: rtl/muldiv_wb_unit.sv
// Multi-cycle MUL/MULHU/DIV/DIVU/REM/REMU unit feeding the register-file write port.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational MUL/MULHU path.
module muldiv_wb_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              kill,
  output logic              busy,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data
);

  state_e            state_q;
  op_e               op_q;
  logic [REG_AW-1:0] rd_q, wb_addr_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, wb_valid_q, neg_quot_q, neg_rem_q, div0_q;

  op_e               op_in;
  logic              accept, in_signed, in_div, op_div_q;
  logic [XLEN-1:0]   abs1, abs2, res_lo, res_hi, res_d;
  logic [2*XLEN-1:0] acc_nxt;

  // Handshake: a request is taken in any cycle with start=1, kill=0, busy=0;
  // busy stays high until the write-back cycle ends, and kill always wins over start.
  assign op_in     = op_e'(op);
  assign accept    = start & ~kill & ~busy_q;
  assign in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
  assign in_div    = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign op_div_q  = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign abs1      = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
  assign abs2      = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept),
    .step_i      ((state_q == RUN) && !kill),
    .div_mode_i  (op_div_q),
    .lo_init_i   (in_div ? abs1 : rs2_data),
    .opnd_init_i (in_div ? abs2 : rs1_data),
    .acc_nxt_o   (acc_nxt)
  );

  assign res_lo = acc_nxt[XLEN-1:0];
  assign res_hi = acc_nxt[2*XLEN-1:XLEN];

  // Result is formed from the final iteration's value so it can be registered into DONE.
  always_comb begin
    res_d = '0;
    case (op_q)
      OP_MUL:          res_d = res_lo;
      OP_MULHU:        res_d = res_hi;
      OP_DIV, OP_DIVU: res_d = div0_q ? XLEN'(DIV0_QUOT) : (neg_quot_q ? -res_lo : res_lo);
      OP_REM, OP_REMU: res_d = neg_rem_q ? -res_hi : res_hi;
      default:         res_d = '0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic              fast_mul;
  assign fast_prod = {{XLEN{1'b0}}, rs1_data} * {{XLEN{1'b0}}, rs2_data};
  assign fast_mul  = (op_in == OP_MUL) || (op_in == OP_MULHU);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      rd_q       <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            rd_q       <= rd;
            cnt_q      <= '0;
            neg_quot_q <= in_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
            neg_rem_q  <= in_signed && rs1_data[XLEN-1];
            div0_q     <= (rs2_data == '0);
            busy_q     <= 1'b1;
            state_q    <= RUN;
`ifdef MULDIV_FAST_MUL_EN
            if (fast_mul) begin
              state_q    <= DONE;
              wb_valid_q <= 1'b1;
              wb_addr_q  <= rd;
              wb_data_q  <= (op_in == OP_MULHU) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
            end
`endif
          end
        end
        RUN: begin
          if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_W'(XLEN-1)) begin
            state_q    <= DONE;
            wb_valid_q <= 1'b1;
            wb_addr_q  <= rd_q;
            wb_data_q  <= res_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign stall    = accept | busy_q;
  assign wb_valid = wb_valid_q & ~kill;
  assign wb_we    = wb_valid & (wb_addr_q != '0);
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Directed-vector bench for muldiv_wb_unit; honours MULDIV_FAST_MUL_EN for expected latency.
module tb_muldiv_wb_unit;
  import muldiv_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        op = 3'd0;
  logic [XLEN-1:0]   rs1_data = '0;
  logic [XLEN-1:0]   rs2_data = '0;
  logic [REG_AW-1:0] rd = '0;
  logic              kill = 1'b0;
  logic              busy, stall, wb_valid, wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;

  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [2:0]        op;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   expd;
  } vec_t;
  vec_t vecs[$];

  muldiv_wb_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd       (rd),
    .kill     (kill),
    .busy     (busy),
    .stall    (stall),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (o == 3'(OP_MUL) || o == 3'(OP_MULHU)) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Scoreboard: every write-back pulse must match the oldest expected result.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=addr %0d data 0x%0h required=no write-back", wb_addr, wb_data);
      end else begin
        check("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver: issue one op at the current negedge and follow it to write-back and beyond.
  task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [REG_AW-1:0] r, input logic [XLEN-1:0] expd);
    int lat;
    int seen;
    bit stall_ok;
    lat = exp_lat(o);
    seen = -1;
    exp_q.push_back(expd);
    op = o; rs1_data = a; rs2_data = b; rd = r; start = 1'b1;
    #1 stall_ok = (stall === 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #1;
    for (int n = 1; n <= 2 * XLEN + 8; n++) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (wb_valid === 1'b1) begin
        seen = n;
        break;
      end
      @(negedge clk);
      #1;
    end
    check("latency", 32'(seen), 32'(lat));
    check("wb_addr", 32'(wb_addr), 32'(r));
    check("wb_we", 32'(wb_we), 32'(r != '0));
    check("stall_through_done", 32'(stall_ok), 32'd1);
    @(negedge clk);
    #1;
    check("busy_after_done", 32'(busy), 32'd0);
    check("wb_valid_after_done", 32'(wb_valid), 32'd0);
    check("wb_data_held", 32'(wb_data), 32'(expd));
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    vecs.push_back('{3'd0, 32'd7,        32'd6,        5'd3,  32'd42});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE});
    vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001});
    vecs.push_back('{3'd0, 32'h00010000, 32'h00010000, 5'd12, 32'h00000000});
    vecs.push_back('{3'd1, 32'h00010000, 32'h00010000, 5'd13, 32'h00000001});
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF});
    vecs.push_back('{3'd2, 32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD});
    vecs.push_back('{3'd4, 32'd7,        32'hFFFFFFFE, 5'd10, 32'h00000001});
    vecs.push_back('{3'd3, 32'd100,      32'd7,        5'd11, 32'd14});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        5'd14, 32'd2});
    vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        5'd15, 32'h7FFFFFFC});
    vecs.push_back('{3'd5, 32'hFFFFFFF9, 32'd2,        5'd16, 32'h00000001});
    vecs.push_back('{3'd2, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF});
    vecs.push_back('{3'd4, 32'd5,        32'd0,        5'd18, 32'd5});
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'd0,        5'd19, 32'hFFFFFFFF});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFF9});
    vecs.push_back('{3'd3, 32'd5,        32'd0,        5'd21, 32'hFFFFFFFF});
    vecs.push_back('{3'd5, 32'd5,        32'd0,        5'd22, 32'd5});
    vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd24, 32'h00000000});
    vecs.push_back('{3'd0, 32'd7,        32'd6,        5'd0,  32'd42});
    vecs.push_back('{3'd6, 32'd123,      32'd456,      5'd25, 32'd0});
    vecs.push_back('{3'd7, 32'hDEADBEEF, 32'd3,        5'd26, 32'd0});

    // Reset state
    wait_cycles(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Table-driven vectors, issued back to back
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].expd);

    // Kill at iteration 10: busy drops next cycle, no write-back ever
    op = 3'd3; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_cycles(9);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_busy_drop", 32'(busy), 32'd0);
    wait_cycles(XLEN + 8);

    // Start together with kill is not accepted
    start = 1'b1; kill = 1'b1;
    #1;
    check("start_kill_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    #1;
    check("start_kill_busy", 32'(busy), 32'd0);
    wait_cycles(XLEN + 4);

    // Start while busy is ignored
    exp_q.push_back(32'd14);
    op = 3'd3; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    begin
      int seen;
      seen = -1;
      #1;
      for (int n = 1; n <= 2 * XLEN + 8; n++) begin
        if (n >= 5 && n <= 7) begin
          op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd = 5'd9; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        #1;
        if (wb_valid === 1'b1) begin
          seen = n;
          break;
        end
        @(negedge clk);
        #1;
      end
      start = 1'b0;
      check("busy_start_latency", 32'(seen), 32'(XLEN + 1));
      check("busy_start_addr", 32'(wb_addr), 32'd4);
    end
    wait_cycles(3);

    // Kill during the write-back cycle suppresses the pulse
    op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd = 5'd11; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_cycles(XLEN - 1);
    @(negedge clk);
    kill = 1'b1;
    #1;
    check("kill_done_wb_valid", 32'(wb_valid), 32'd0);
    check("kill_done_wb_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check("kill_done_busy", 32'(busy), 32'd0);
    wait_cycles(3);

    // Reset mid-RUN clears everything at once
    op = 3'd2; rs1_data = 32'hFFFFFFF9; rs2_data = 32'd2; rd = 5'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_cycles(14);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_wb_addr", 32'(wb_addr), 32'd0);
    check("midrst_wb_data", 32'(wb_data), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    run_op(3'd0, 32'd7, 32'd6, 5'd3, 32'd42);
    run_op(3'd3, 32'd100, 32'd7, 5'd4, 32'd14);

    // Final report
    wait_cycles(4);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
